// File: rtl/can_pkg.sv
// Shared CAN constants used by the transmit bit stuffer and the receive de-stuffer.
package can_pkg;

    localparam int unsigned CAN_STUFF_LEN = 5;
    localparam logic        CAN_DOMINANT  = 1'b0;
    localparam logic        CAN_RECESSIVE = 1'b1;
    localparam int unsigned CAN_CNT_W     = 3;

endpackage

// File: rtl/can_bit_stuffer.sv
// Transmit-side CAN bit stuffer: drives TX from the unstuffed framer stream, inserting a
// complementary stuff bit after STUFF_LEN identical bits while F_STF is high.
module can_bit_stuffer
    import can_pkg::*;
#(
    parameter int unsigned STUFF_LEN = CAN_STUFF_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic SP,
    input  logic F_STF,
    input  logic tx_valid,
    input  logic tx_data,
    output logic tx_ready,
    output logic TX,
    output logic stuff_bit,
    output logic underrun
);

    logic                 last_q, last_d;
    logic [CAN_CNT_W-1:0] cnt_q, cnt_d;
    logic                 tx_q, tx_d;
    logic                 stuff_q, stuff_d;
    logic                 underrun_q, underrun_d;
    logic                 stuff_due;
    logic                 run_full;

    assign run_full  = (cnt_q == CAN_CNT_W'(STUFF_LEN));
    assign stuff_due = F_STF & run_full;
    assign tx_ready  = SP & ~stuff_due;

    always_comb begin
        last_d     = last_q;
        cnt_d      = cnt_q;
        tx_d       = tx_q;
        stuff_d    = stuff_q;
        underrun_d = 1'b0;
        if (SP) begin
            if (stuff_due) begin
                // The stuff bit opens the next run, so the count restarts at one.
                tx_d    = ~last_q;
                stuff_d = 1'b1;
                last_d  = ~last_q;
                cnt_d   = CAN_CNT_W'(1);
            end else if (tx_valid) begin
                tx_d    = tx_data;
                stuff_d = 1'b0;
                last_d  = tx_data;
                if (!F_STF) begin
                    cnt_d = '0;
                end else if (tx_data == last_q) begin
                    cnt_d = run_full ? cnt_q : cnt_q + CAN_CNT_W'(1);
                end else begin
                    cnt_d = CAN_CNT_W'(1);
                end
            end else begin
                tx_d       = CAN_RECESSIVE;
                stuff_d    = 1'b0;
                last_d     = CAN_RECESSIVE;
                cnt_d      = '0;
                underrun_d = F_STF;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q     <= CAN_RECESSIVE;
            cnt_q      <= '0;
            tx_q       <= CAN_RECESSIVE;
            stuff_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            tx_q       <= tx_d;
            stuff_q    <= stuff_d;
            underrun_q <= underrun_d;
        end
    end

    assign TX        = tx_q;
    assign stuff_bit = stuff_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_can_bit_stuffer.sv
// Self-checking bench for can_bit_stuffer: expected bus outputs are queued per bit time.
module tb_can_bit_stuffer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic SP = 1'b0;
    logic F_STF = 1'b0;
    logic tx_valid = 1'b0;
    logic tx_data = 1'b1;
    logic tx_ready;
    logic TX;
    logic stuff_bit;
    logic underrun;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    can_bit_stuffer #(.STUFF_LEN(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .SP        (SP),
        .F_STF     (F_STF),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .TX        (TX),
        .stuff_bit (stuff_bit),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    // One bit time: SP in this cycle, tx_ready checked same cycle, outputs after the edge.
    task automatic sp_cycle(input string nm, input logic f, input logic v, input logic d,
                            input logic er, input logic etx, input logic est, input logic eun);
        logic [2:0] e;
        exp_q.push_back({etx, est, eun});
        @(negedge clk);
        SP = 1'b1; F_STF = f; tx_valid = v; tx_data = d;
        #1;
        checks++;
        if (tx_ready !== er) begin
            errors++;
            $display("FAIL %s tx_ready got %b want %b", nm, tx_ready, er);
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({TX, stuff_bit, underrun} !== e) begin
            errors++;
            $display("FAIL %s {TX,stuff,underrun} got %b%b%b want %b", nm, TX, stuff_bit, underrun, e);
        end
    endtask

    task automatic gap(input int n);
        @(negedge clk);
        SP = 1'b0; tx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        SP = 1'b0; F_STF = 1'b0; tx_valid = 1'b0; tx_data = 1'b1;
        reset = 1'b0;
        #1;
        checks++;
        if ({TX, stuff_bit, underrun} !== 3'b100) begin
            errors++;
            $display("FAIL reset_state got %b%b%b want 100", TX, stuff_bit, underrun);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset_idle();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            sp_cycle("idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            gap(1);
            checks++;
            if (tx_ready !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_sp tx_ready got %b want 0", tx_ready);
            end
        end
    endtask

    task automatic test_six_zeros();
        do_reset();
        for (int i = 0; i < 7; i++)
            sp_cycle("six_zeros", 1'b1, 1'b1, 1'b0, i != 5, i == 5, i == 5, 1'b0);
        gap(1);
    endtask

    task automatic test_stuff_starts_run();
        do_reset();
        for (int i = 0; i < 10; i++)
            sp_cycle("ones_run", 1'b1, 1'b1, 1'b1, i != 5, i != 5, i == 5, 1'b0);
        sp_cycle("ones_run_end", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        gap(1);
    endtask

    task automatic test_mixed_runs();
        do_reset();
        for (int i = 0; i < 11; i++) begin
            sp_cycle("mixed", 1'b1, 1'b1, i >= 4, i != 9, (i >= 4) && (i != 9), i == 9, 1'b0);
            if (i % 3 == 0) gap(2);
        end
        gap(1);
    endtask

    task automatic test_fstf_drop_and_underrun();
        do_reset();
        for (int i = 0; i < 5; i++)
            sp_cycle("fstf_run", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        sp_cycle("fstf_drop", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        sp_cycle("fstf_off", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        sp_cycle("fstf_back", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        sp_cycle("underrun", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        SP = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({TX, stuff_bit, underrun} !== 3'b100) begin
            errors++;
            $display("FAIL underrun_clear got %b%b%b want 100", TX, stuff_bit, underrun);
        end
        // Underrun after a fresh run: run restarts from recessive idle.
        for (int i = 0; i < 5; i++)
            sp_cycle("after_underrun", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        sp_cycle("after_underrun_stuff", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        gap(1);
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        for (int i = 0; i < 4; i++)
            sp_cycle("pre_reset", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        SP = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if ({TX, stuff_bit, underrun} !== 3'b100) begin
            errors++;
            $display("FAIL mid_reset got %b%b%b want 100", TX, stuff_bit, underrun);
        end
        @(negedge clk);
        SP = 1'b1; F_STF = 1'b1; tx_valid = 1'b1; tx_data = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (TX !== 1'b1) begin
            errors++;
            $display("FAIL sp_during_reset TX got %b want 1", TX);
        end
        @(negedge clk);
        SP = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 7; i++)
            sp_cycle("post_reset", 1'b1, 1'b1, 1'b0, i != 5, i == 5, i == 5, 1'b0);
        gap(1);
    endtask

    initial begin
        test_reset_idle();
        test_six_zeros();
        test_stuff_starts_run();
        test_mixed_runs();
        test_fstf_drop_and_underrun();
        test_reset_mid_run();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/can_bit_stuffer.md
# can_bit_stuffer

Transmit-side CAN bit stuffer, the counterpart of the receive-side de-stuffing block. It takes the unstuffed serial frame stream from the TX framer one bit per bit time, and drives the bus TX line. After STUFF_LEN consecutive identical bits, it inserts one complementary stuff bit while the framer asserts F_STF. It sits between the frame serializer and the TX pin driver and runs off the bit-timing strobe SP.

## Interface
- STUFF_LEN, 5, run length that triggers a stuff bit (CAN: 5); legal range 2..7
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- SP  in  1  bit-time strobe, one clk-cycle pulse per nominal bit; TX advances only on SP
- F_STF  in  1  stuffing enable from framer (high SOF..last CRC bit), sampled at SP
- tx_valid  in  1  framer has a data bit on tx_data
- tx_data  in  1  next unstuffed bit (0 = dominant)
- tx_ready  out  1  combinational; high in the SP cycle when tx_data is consumed
- TX  out  1  registered bus output (1 = recessive)
- stuff_bit  out  1  registered; high for the whole bit time in which TX carries a stuff bit
- underrun  out  1  registered one-cycle pulse: SP with F_STF=1, no stuff due, tx_valid=0

## Operation
- State: last (1 b, last bit driven), cnt (3 b, run length of last, 0..STUFF_LEN).
- stuff_due = F_STF & (cnt == STUFF_LEN).
- tx_ready = SP & ~stuff_due. A bit is consumed when SP & tx_ready & tx_valid. The framer must present the bit and hold it until it is consumed.
- At SP, with priority in this order:
  - stuff_due: TX <= ~last, stuff_bit <= 1, last <= ~last, cnt <= 1. No data consumed.
  - tx_valid: TX <= tx_data, stuff_bit <= 0, last <= tx_data.
    - If F_STF=0: cnt <= 0.
    - Else if tx_data == last: cnt <= cnt+1.
    - Else: cnt <= 1.
  - else (no data): TX <= 1, stuff_bit <= 0, last <= 1, cnt <= 0. underrun <= F_STF.
- The stuff bit counts as the first bit of the next run, per CAN.
- F_STF=0 with a pending run of STUFF_LEN: no stuff bit is inserted, and cnt clears. The framer keeps F_STF high through the bit time after the last CRC bit, so a final stuff bit can still be inserted there.
- Without SP, all registers hold. underrun returns to 0 on the next clk.
- cnt saturates at STUFF_LEN. It cannot exceed STUFF_LEN because the stuff bit resets it.

## Timing
- Reset (async assert, synchronous release): TX=1, stuff_bit=0, underrun=0, last=1, cnt=0.
- Latency: TX, stuff_bit and underrun update on the clk edge that samples SP=1. They are valid one clk after the SP cycle and stable for the whole bit time.
- tx_ready has zero latency: it is a same-cycle combinational function of SP, F_STF and cnt.
- SP asserted on consecutive clk cycles is legal; each pulse is treated as one bit time.
- Reset mid-frame aborts immediately. TX goes recessive and the run history is lost; the first bit after release starts a fresh run (cnt was 0).
- SP coincident with reset assertion: reset wins.

## Structure
- Shared CAN package (can_pkg):
  - CAN_STUFF_LEN = 5
  - CAN_DOMINANT = 1'b0, CAN_RECESSIVE = 1'b1
  - run-counter width constant, shared with the de-stuffing block
- No sub-module. The run counter and last-bit register are small enough to live inline. The datapath is a single always block plus the tx_ready assign.

## Test plan
- Reset then idle SP pulses, tx_valid=0, F_STF=0 -> TX=1, stuff_bit=0, underrun=0, tx_ready pulses with each SP.
- F_STF=1, data 0,0,0,0,0,0 -> TX 0,0,0,0,0,1(stuff_bit=1),0. tx_ready low on the 6th SP; the 6th data bit is held and emitted on the 7th SP.
- F_STF=1, data 1×5 then 1,1,1,1 -> TX 1,1,1,1,1,0(stuff),1,1,1,1. The stuff bit starts a new run, so there is no second stuff bit after the following four 1s.
- F_STF=1, data 0×4, 1×5 -> a stuff 0 appears only after the five 1s; no stuff after the four 0s.
- F_STF=1, five 0s, then F_STF dropped before the next SP -> no stuff bit, cnt clears, TX follows tx_data. Separately, SP with F_STF=1, tx_valid=0, no stuff due -> TX=1 and a one-cycle underrun pulse.
- reset asserted mid-run (cnt=4) between SPs -> TX=1 immediately. After release, data 0×5 -> a stuff bit occurs after exactly five 0s.
